// File: rtl/register_bank8.sv
// Eight-entry register file fed by a one-hot write select, with two combinational read ports.
// Optional same-cycle write-to-read forwarding is enabled by defining REG_BYPASS_EN.
module register_bank8 #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       to_reg,
  input  logic [WIDTH-1:0] d_in,
  input  logic [2:0]       rAddr0,
  input  logic [2:0]       rAddr1,
  input  logic             err_clr,
  output logic [WIDTH-1:0] rData0,
  output logic [WIDTH-1:0] rData1,
  output logic             onehot_err,
  output logic [7:0]       wr_cnt
);

  logic [WIDTH-1:0] r_regs [8];
  logic             r_err;
  logic [7:0]       r_wr_cnt;

  logic             w_zero;
  logic             w_multi;
  logic             w_onehot;
  logic [7:0]       w_we;
  logic [2:0]       w_addr  [2];
  logic [WIDTH-1:0] w_rdata [2];

  // Clearing the lowest set bit leaves something behind only when two or more bits were set.
  assign w_zero   = (to_reg == 8'd0);
  assign w_multi  = !w_zero && ((to_reg & (to_reg - 8'd1)) != 8'd0);
  assign w_onehot = !w_zero && !w_multi;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_we
      assign w_we[gi] = w_onehot && to_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) begin
        r_regs[i] <= RESET_VAL;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (w_we[i]) begin
          r_regs[i] <= d_in;
        end
      end
    end
  end

  // A multi-hot select on the same edge as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err    <= 1'b0;
      r_wr_cnt <= 8'd0;
    end else begin
      if (w_multi) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
      if (w_onehot) begin
        r_wr_cnt <= r_wr_cnt + 8'd1;
      end
    end
  end

  assign w_addr[0] = rAddr0;
  assign w_addr[1] = rAddr1;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
`ifdef REG_BYPASS_EN
      assign w_rdata[gi] = w_we[w_addr[gi]] ? d_in : r_regs[w_addr[gi]];
`else
      assign w_rdata[gi] = r_regs[w_addr[gi]];
`endif
    end
  endgenerate

  assign rData0     = w_rdata[0];
  assign rData1     = w_rdata[1];
  assign onehot_err = r_err;
  assign wr_cnt     = r_wr_cnt;

endmodule

// File: tb/tb_register_bank8.sv
// Randomized and directed self-checking bench for register_bank8 against an array-based model.
// Expectations follow REG_BYPASS_EN when the bench is built with that macro.
module tb_register_bank8;

  logic        clk;
  logic        reset_n;
  logic [7:0]  to_reg;
  logic [31:0] d_in;
  logic [2:0]  rAddr0;
  logic [2:0]  rAddr1;
  logic        err_clr;
  logic [31:0] rData0;
  logic [31:0] rData1;
  logic        onehot_err;
  logic [7:0]  wr_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_regs [8];
  logic        m_err;
  logic [7:0]  m_cnt;

  register_bank8 #(.WIDTH(32), .RESET_VAL(32'h0)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .to_reg     (to_reg),
    .d_in       (d_in),
    .rAddr0     (rAddr0),
    .rAddr1     (rAddr1),
    .err_clr    (err_clr),
    .rData0     (rData0),
    .rData1     (rData1),
    .onehot_err (onehot_err),
    .wr_cnt     (wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 32'h0;
    m_err = 1'b0;
    m_cnt = 8'd0;
  endtask

  // Value a read port should show before the edge, given the inputs currently driven.
  function automatic logic [31:0] exp_read(input logic [2:0] addr);
    logic [31:0] v;
    v = m_regs[addr];
`ifdef REG_BYPASS_EN
    if ($countones(to_reg) == 1 && to_reg[addr]) v = d_in;
`endif
    return v;
  endfunction

  task automatic model_edge(input logic [7:0] to, input logic [31:0] d, input logic clr);
    int ones;
    ones = $countones(to);
    if (ones == 1) begin
      for (int i = 0; i < 8; i++) if (to[i]) m_regs[i] = d;
      m_cnt = m_cnt + 8'd1;
    end
    if (ones > 1) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
  endtask

  // One transaction: drive, check reads mid-cycle, clock, check flag and counter after the edge.
  task automatic do_cycle(input string tag, input logic [7:0] to, input logic [31:0] d,
                          input logic [2:0] a0, input logic [2:0] a1, input logic clr);
    to_reg  = to;
    d_in    = d;
    rAddr0  = a0;
    rAddr1  = a1;
    err_clr = clr;
    #2;
    check_eq({tag, "/rData0"}, rData0, exp_read(a0));
    check_eq({tag, "/rData1"}, rData1, exp_read(a1));
    @(posedge clk);
    model_edge(to, d, clr);
    #1;
    check_eq({tag, "/onehot_err"}, {31'b0, onehot_err}, {31'b0, m_err});
    check_eq({tag, "/wr_cnt"}, {24'b0, wr_cnt}, {24'b0, m_cnt});
    $display("%s to=%b d=%h a0=%0d a1=%0d clr=%b -> cnt=%0d err=%b",
             tag, to, d, a0, a1, clr, wr_cnt, onehot_err);
  endtask

  // Asserts reset mid-cycle while a write is pending; that write must be lost.
  task automatic mid_reset(input string tag);
    to_reg  = 8'h08;
    d_in    = 32'hCAFEF00D;
    rAddr0  = 3'd3;
    rAddr1  = 3'd0;
    err_clr = 1'b0;
    #1;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_eq({tag, "/rData0"}, rData0, 32'h0);
    check_eq({tag, "/rData1"}, rData1, 32'h0);
    check_eq({tag, "/onehot_err"}, {31'b0, onehot_err}, 32'h0);
    check_eq({tag, "/wr_cnt"}, {24'b0, wr_cnt}, 32'h0);
    $display("%s reset asserted mid-cycle", tag);
    @(posedge clk);
    @(negedge clk);
    to_reg  = 8'h00;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  rto;
    logic [31:0] rd;
    int          kind;

    reset_n = 1'b0;
    to_reg  = 8'h00;
    d_in    = 32'h0;
    rAddr0  = 3'd0;
    rAddr1  = 3'd1;
    err_clr = 1'b0;
    model_reset();
    #2;
    check_eq("por/rData0", rData0, 32'h0);
    check_eq("por/rData1", rData1, 32'h0);
    check_eq("por/onehot_err", {31'b0, onehot_err}, 32'h0);
    check_eq("por/wr_cnt", {24'b0, wr_cnt}, 32'h0);
    $display("por reset state checked");
    #6;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    do_cycle("basic_wr", 8'b0000_0100, 32'hDEADBEEF, 3'd2, 3'd3, 1'b0);
    do_cycle("basic_rd", 8'h00, 32'h0, 3'd2, 3'd3, 1'b0);
    check_eq("basic/rData0_const", rData0, 32'hDEADBEEF);
    check_eq("basic/rData1_const", rData1, 32'h0);
    check_eq("basic/wr_cnt_const", {24'b0, wr_cnt}, 32'd1);

    do_cycle("pre_r1", 8'b0000_0010, 32'h11, 3'd1, 3'd5, 1'b0);
    do_cycle("pre_r5", 8'b0010_0000, 32'h55, 3'd1, 3'd5, 1'b0);
    do_cycle("multi", 8'b0010_0010, 32'hFFFFFFFF, 3'd1, 3'd5, 1'b0);
    check_eq("multi/err_const", {31'b0, onehot_err}, 32'd1);
    check_eq("multi/cnt_const", {24'b0, wr_cnt}, 32'd3);
    do_cycle("clr", 8'h00, 32'h0, 3'd1, 3'd5, 1'b1);
    check_eq("multi/r1_const", rData0, 32'h11);
    check_eq("multi/r5_const", rData1, 32'h55);
    check_eq("clr/err_const", {31'b0, onehot_err}, 32'd0);

    do_cycle("setwins", 8'b1100_0000, 32'h12345678, 3'd6, 3'd7, 1'b1);
    check_eq("setwins/err_const", {31'b0, onehot_err}, 32'd1);
    do_cycle("hold", 8'h00, 32'h0, 3'd6, 3'd7, 1'b0);
    do_cycle("clr2", 8'h00, 32'h0, 3'd6, 3'd7, 1'b1);

    // Same-cycle read of the register being written.
    to_reg  = 8'b1000_0000;
    d_in    = 32'hA5A5A5A5;
    rAddr0  = 3'd7;
    rAddr1  = 3'd7;
    err_clr = 1'b0;
    #2;
`ifdef REG_BYPASS_EN
    check_eq("raw/in_cycle", rData0, 32'hA5A5A5A5);
`else
    check_eq("raw/in_cycle", rData0, 32'h0);
`endif
    do_cycle("raw_wr", 8'b1000_0000, 32'hA5A5A5A5, 3'd7, 3'd7, 1'b0);
    do_cycle("raw_rd", 8'h00, 32'h0, 3'd7, 3'd0, 1'b0);
    check_eq("raw/after", rData0, 32'hA5A5A5A5);

    mid_reset("midrst");
    do_cycle("midrst_rd", 8'h00, 32'h0, 3'd3, 3'd7, 1'b0);
    check_eq("midrst/r3_const", rData0, 32'h0);

    for (int i = 0; i < 256; i++) begin
      do_cycle("sweep", 8'(1 << (i % 8)), 32'(i), 3'(i % 8), 3'((i + 1) % 8), 1'b0);
    end
    check_eq("sweep/wrap_cnt", {24'b0, wr_cnt}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      do_cycle("sweep_rd", 8'h00, 32'h0, 3'(i), 3'(7 - i), 1'b0);
      check_eq("sweep/reg_const", rData0, 32'(248 + i));
    end

    for (int n = 0; n < 300; n++) begin
      kind = int'($urandom_range(0, 9));
      if (kind < 2)      rto = 8'h00;
      else if (kind < 8) rto = 8'(1 << $urandom_range(0, 7));
      else               rto = 8'($urandom) | 8'h81;
      rd = $urandom;
      do_cycle("rand", rto, rd, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
               ($urandom_range(0, 7) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
